// File: rtl/irq_ctrl_wb.sv
// Machine-external interrupt controller: synchronizes and latches N_SRC sources,
// raises meip_o to the core, and is serviced over a Wishbone classic slave port.

module irq_ctrl_wb_lane (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  output logic pending
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      pending <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
      // set wins over a same-cycle clear
      if (edge_mode) pending <= (s2 & ~s3) | (pending & ~clr);
      else           pending <= s2;
    end
  end
endmodule

module irq_ctrl_wb #(
  parameter int N_SRC = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_SRC-1:0] irq_src_i,
  output logic             meip_o,
  input  logic             irq_ack_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o
);
  localparam int ID_W = (N_SRC > 15) ? 5 : 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_INSVC = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [N_SRC-1:0] pending, enable, edge_cfg, act, win_oh, lane_clr;
  logic [ID_W-1:0]  claim_id, win_id;
  logic [1:0]       reg_sel;
  logic             wb_req, wr_full, complete, ack_take;
  logic [31:0]      rdata;
  logic             unused;

  assign unused   = ^{wb_adr_i[1:0], wb_dat_i};
  assign reg_sel  = wb_adr_i[3:2];
  // back-to-back requests are throttled to one ack every other cycle
  assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_full  = wb_req & wb_we_i & (wb_sel_i == 4'hF);
  assign complete = wr_full & (reg_sel == 2'd3);

  assign act      = pending & enable;
  assign win_oh   = act & (~act + N_SRC'(1));
  assign ack_take = (state == S_ARMED) & irq_ack_i;
  assign lane_clr = ((wr_full && reg_sel == 2'd0) ? wb_dat_i[N_SRC-1:0] : '0)
                  | (ack_take ? win_oh : '0);

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_lane
      irq_ctrl_wb_lane u_lane (
        .clk       (clk_i),
        .rst       (reset_i),
        .src       (irq_src_i[g]),
        .edge_mode (edge_cfg[g]),
        .clr       (lane_clr[g]),
        .pending   (pending[g])
      );
    end
  endgenerate

  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i]) win_id = ID_W'(i + 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|act) state_nxt = S_ARMED;
      S_ARMED: begin
        if (irq_ack_i)    state_nxt = S_INSVC;
        else if (~|act)   state_nxt = S_IDLE;
      end
      S_INSVC: if (complete) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[N_SRC-1:0] = pending;
      2'd1: rdata[N_SRC-1:0] = enable;
      2'd2: rdata[N_SRC-1:0] = edge_cfg;
      default: begin
        rdata[ID_W-1:0]      = claim_id;
        rdata[ID_W+1:ID_W]   = state;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      meip_o   <= 1'b0;
      claim_id <= '0;
      enable   <= '0;
      edge_cfg <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state  <= state_nxt;
      meip_o <= (state_nxt == S_ARMED);
      // win_id is 0 when the active set vanished in the ack cycle
      if (ack_take) claim_id <= win_id;
      if (wr_full && reg_sel == 2'd1) enable   <= wb_dat_i[N_SRC-1:0];
      if (wr_full && reg_sel == 2'd2) edge_cfg <= wb_dat_i[N_SRC-1:0];
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= rdata;
    end
  end
endmodule

// File: tb/tb_irq_ctrl_wb.sv
// Directed bench for irq_ctrl_wb: edge/level paths, priority, withdrawal,
// same-cycle collisions, Wishbone throttling and byte-select handling.

module tb_irq_ctrl_wb;
  logic        clk, reset_i;
  logic [7:0]  irq_src_i;
  logic        meip_o, irq_ack_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_adr_i, wb_sel_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;

  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl_wb #(.N_SRC(8)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .irq_src_i (irq_src_i),
    .meip_o    (meip_o),
    .irq_ack_i (irq_ack_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (wb_ack_o) tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_rd(input logic [3:0] adr, output logic [31:0] d);
    if (wb_ack_o) tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = adr;  wb_sel_i = 4'hF;
    tick();
    chk("rd_ack", {31'b0, wb_ack_o}, 32'd1);
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int acks;
    reset_i = 1'b1; irq_src_i = '0; irq_ack_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;

    // reset held while sources toggle
    tick(); irq_src_i = 8'hFF; tick(); irq_src_i = 8'h00; tick(); irq_src_i = 8'hFF; tick();
    chk("rst_meip", {31'b0, meip_o}, 32'd0);
    chk("rst_ack",  {31'b0, wb_ack_o}, 32'd0);
    chk("rst_dat",  wb_dat_o, 32'd0);
    irq_src_i = 8'h00;
    tick(); tick();
    reset_i = 1'b0;
    tick(); tick();
    wb_rd(4'h0, rd); chk("rst_pending", rd, 32'h0);
    wb_rd(4'h4, rd); chk("rst_enable",  rd, 32'h0);
    wb_rd(4'h8, rd); chk("rst_edge",    rd, 32'h0);
    wb_rd(4'hC, rd); chk("rst_claim",   rd, 32'h0);

    // edge path on source 0
    wb_wr(4'h8, 32'h01, 4'hF);
    wb_wr(4'h4, 32'h01, 4'hF);
    irq_src_i = 8'h01; tick();
    irq_src_i = 8'h00; tick(); tick();
    chk("edge_meip_e2", {31'b0, meip_o}, 32'd0);
    tick();
    chk("edge_meip_e3", {31'b0, meip_o}, 32'd1);
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
    chk("edge_ack_meip", {31'b0, meip_o}, 32'd0);
    wb_rd(4'hC, rd); chk("edge_claim", rd, 32'h21);
    wb_rd(4'h0, rd); chk("edge_pending", rd, 32'h0);
    wb_wr(4'hC, 32'h0, 4'hF);
    chk("edge_cmpl_meip0", {31'b0, meip_o}, 32'd0);
    tick(); tick();
    chk("edge_cmpl_meip2", {31'b0, meip_o}, 32'd0);
    wb_rd(4'hC, rd); chk("edge_claim_idle", rd, 32'h01);

    // priority between level sources 3 and 5
    wb_wr(4'h8, 32'h00, 4'hF);
    wb_wr(4'h4, 32'hFF, 4'hF);
    irq_src_i = 8'h28;
    repeat (5) tick();
    chk("prio_meip", {31'b0, meip_o}, 32'd1);
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
    chk("prio_ack_meip", {31'b0, meip_o}, 32'd0);
    wb_rd(4'hC, rd); chk("prio_claim", rd, 32'h24);
    wb_rd(4'h0, rd); chk("prio_pending", rd, 32'h28);
    wb_wr(4'hC, 32'h0, 4'hF);
    chk("prio_cmpl_c", {31'b0, meip_o}, 32'd0);
    tick();
    chk("prio_rearm", {31'b0, meip_o}, 32'd1);
    irq_src_i = 8'h00;
    repeat (5) tick();
    chk("prio_drop", {31'b0, meip_o}, 32'd0);

    // withdrawal by masking
    irq_src_i = 8'h04;
    repeat (5) tick();
    chk("wd_meip", {31'b0, meip_o}, 32'd1);
    wb_wr(4'h4, 32'h00, 4'hF);
    chk("wd_meip_w", {31'b0, meip_o}, 32'd1);
    tick();
    chk("wd_meip_w1", {31'b0, meip_o}, 32'd0);
    wb_rd(4'hC, rd); chk("wd_claim", rd, 32'h04);

    // ack in the same cycle the active set empties
    wb_wr(4'h4, 32'hFF, 4'hF);
    tick();
    chk("col_armed", {31'b0, meip_o}, 32'd1);
    wb_wr(4'h4, 32'h00, 4'hF);
    irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
    chk("col_meip", {31'b0, meip_o}, 32'd0);
    wb_rd(4'hC, rd); chk("col_claim", rd, 32'h20);
    wb_wr(4'hC, 32'h0, 4'hF);
    wb_rd(4'hC, rd); chk("col_claim_idle", rd, 32'h00);
    irq_src_i = 8'h00;

    // W1C colliding with a new rising edge on source 1
    wb_wr(4'h8, 32'h02, 4'hF);
    irq_src_i = 8'h02; tick(); tick();
    wb_wr(4'h0, 32'h02, 4'hF);
    wb_rd(4'h0, rd); chk("w1c_collide", rd, 32'h02);
    wb_wr(4'h0, 32'h02, 4'hF);
    wb_rd(4'h0, rd); chk("w1c_clear", rd, 32'h00);

    // held strobe: one ack every other cycle
    if (wb_ack_o) tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h4;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    chk("hold_acks", acks, 32'd3);

    // partial byte-select writes are acked but dropped
    wb_wr(4'h4, 32'hFF, 4'h3);
    chk("sel_ack", {31'b0, wb_ack_o}, 32'd1);
    wb_rd(4'h4, rd); chk("sel_enable", rd, 32'h00);
    wb_wr(4'h4, 32'hFFFF_FFFF, 4'hF);
    wb_rd(4'h4, rd); chk("enable_width", rd, 32'hFF);
    wb_rd(4'h8, rd); chk("edge_keep", rd, 32'h02);

    // reset while ARMED
    irq_src_i = 8'h10;
    repeat (5) tick();
    chk("mid_armed", {31'b0, meip_o}, 32'd1);
    #1 reset_i = 1'b1;
    #1 chk("mid_rst_meip", {31'b0, meip_o}, 32'd0);
    irq_src_i = 8'h00;
    tick(); tick();
    reset_i = 1'b0;
    tick();
    wb_rd(4'h4, rd); chk("mid_enable", rd, 32'h00);
    wb_rd(4'hC, rd); chk("mid_claim", rd, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
